// File: rtl/ctrl_pipe_if.sv
// Decoder-pipe bundle: ID-stage instruction fields in, per-stage control words out.
// CTRL_PERF_EN adds the retired/stall performance counters to the bundle.
interface ctrl_pipe_if #(
    parameter int unsigned ALU_W = 5,
    parameter int unsigned EXT_W = 2,
    parameter int unsigned REG_W = 5
);
    localparam int unsigned CW = 11 + ALU_W + EXT_W;

    logic             instr_valid;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             flush_i;
    logic             mem_stall_i;
    logic             stall_o;
    logic             illegal_o;
    logic [CW-1:0]    ex_ctrl;
    logic [CW-1:0]    mem_ctrl;
    logic [CW-1:0]    wb_ctrl;
    logic [REG_W-1:0] ex_wreg;
    logic [REG_W-1:0] mem_wreg;
    logic [REG_W-1:0] wb_wreg;
    logic             halted_o;
`ifdef CTRL_PERF_EN
    logic [31:0]      retired_cnt;
    logic [31:0]      stall_cnt;

    modport master (
        output instr_valid, opcode, funct, rs, rt, rd, flush_i, mem_stall_i,
        input  stall_o, illegal_o, ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_wreg, mem_wreg, wb_wreg, halted_o, retired_cnt, stall_cnt
    );
    modport slave (
        input  instr_valid, opcode, funct, rs, rt, rd, flush_i, mem_stall_i,
        output stall_o, illegal_o, ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_wreg, mem_wreg, wb_wreg, halted_o, retired_cnt, stall_cnt
    );
`else
    modport master (
        output instr_valid, opcode, funct, rs, rt, rd, flush_i, mem_stall_i,
        input  stall_o, illegal_o, ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_wreg, mem_wreg, wb_wreg, halted_o
    );
    modport slave (
        input  instr_valid, opcode, funct, rs, rt, rd, flush_i, mem_stall_i,
        output stall_o, illegal_o, ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_wreg, mem_wreg, wb_wreg, halted_o
    );
`endif
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelined main decoder: ID decode, control carry through EX/MEM/WB, load-use interlock
// and BREAK drain-then-halt. Define CTRL_PERF_EN for the retired/stall counters.
module ctrl_pipe #(
    parameter int unsigned ALU_W = 5,
    parameter int unsigned EXT_W = 2,
    parameter int unsigned REG_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_pipe_if.slave bus
);
    localparam int unsigned CW = 11 + ALU_W + EXT_W;

    localparam logic [ALU_W-1:0] ALUOP_ADDU = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALUOP_SUBU = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALUOP_AND  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALUOP_OR   = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALUOP_XOR  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALUOP_SLT  = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALUOP_SLL  = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALUOP_SRL  = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALUOP_SRA  = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALUOP_LUI  = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALUOP_ADD  = ALU_W'(10);

    localparam logic [EXT_W-1:0] EXT_ZERO = EXT_W'(0);
    localparam logic [EXT_W-1:0] EXT_SIGN = EXT_W'(1);
    localparam logic [EXT_W-1:0] EXT_HIGH = EXT_W'(2);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef struct packed {
        logic             jump;
        logic             branch;
        logic             nbranch;
        logic             regdst;
        logic             alusrc;
        logic             alushift;
        logic             memr;
        logic             mem2r;
        logic             memw;
        logic             regw;
        logic             brk;
        logic [EXT_W-1:0] extop;
        logic [ALU_W-1:0] aluctrl;
    } ctrl_t;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

    state_t           state;
    ctrl_t            dec;
    ctrl_t            id_ctrl;
    ctrl_t            ex_q;
    ctrl_t            mem_q;
    ctrl_t            wb_q;
    logic [REG_W-1:0] id_wreg;
    logic [REG_W-1:0] ex_wreg_q;
    logic [REG_W-1:0] mem_wreg_q;
    logic [REG_W-1:0] wb_wreg_q;
    logic             legal;
    logic             uses_rt;
    logic             hazard;
    logic             stall_c;

    // Raw opcode/funct decode; unlisted encodings flag illegal.
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (bus.opcode)
            OP_RTYPE: begin
                dec.regw = 1'b1;
                case (bus.funct)
                    FN_ADDU:  dec.aluctrl = ALUOP_ADDU;
                    FN_SUBU:  dec.aluctrl = ALUOP_SUBU;
                    FN_SLT:   dec.aluctrl = ALUOP_SLT;
                    FN_AND:   dec.aluctrl = ALUOP_AND;
                    FN_OR:    dec.aluctrl = ALUOP_OR;
                    FN_XOR:   dec.aluctrl = ALUOP_XOR;
                    FN_SLL: begin
                        dec.alushift = 1'b1;
                        dec.aluctrl  = ALUOP_SLL;
                    end
                    FN_SRL: begin
                        dec.alushift = 1'b1;
                        dec.aluctrl  = ALUOP_SRL;
                    end
                    FN_SRA: begin
                        dec.alushift = 1'b1;
                        dec.aluctrl  = ALUOP_SRA;
                    end
                    FN_BREAK: begin
                        dec.regw = 1'b0;
                        dec.brk  = 1'b1;
                    end
                    default: begin
                        dec.regw = 1'b0;
                        legal    = 1'b0;
                    end
                endcase
            end
            OP_ORI: begin
                dec.regdst  = 1'b1;
                dec.alusrc  = 1'b1;
                dec.regw    = 1'b1;
                dec.extop   = EXT_ZERO;
                dec.aluctrl = ALUOP_OR;
            end
            OP_LUI: begin
                dec.regdst  = 1'b1;
                dec.alusrc  = 1'b1;
                dec.regw    = 1'b1;
                dec.extop   = EXT_HIGH;
                dec.aluctrl = ALUOP_LUI;
            end
            OP_LW: begin
                dec.regdst  = 1'b1;
                dec.alusrc  = 1'b1;
                dec.memr    = 1'b1;
                dec.mem2r   = 1'b1;
                dec.regw    = 1'b1;
                dec.extop   = EXT_SIGN;
                dec.aluctrl = ALUOP_ADDU;
            end
            OP_SW: begin
                dec.alusrc  = 1'b1;
                dec.memw    = 1'b1;
                dec.extop   = EXT_SIGN;
                dec.aluctrl = ALUOP_ADDU;
            end
            OP_BEQ: begin
                dec.branch  = 1'b1;
                dec.extop   = EXT_SIGN;
                dec.aluctrl = ALUOP_SUBU;
            end
            OP_BNE: begin
                dec.nbranch = 1'b1;
                dec.extop   = EXT_SIGN;
                dec.aluctrl = ALUOP_SUBU;
            end
            OP_J:     dec.jump = 1'b1;
            OP_ADDI: begin
                dec.regdst  = 1'b1;
                dec.alusrc  = 1'b1;
                dec.regw    = 1'b1;
                dec.extop   = EXT_SIGN;
                dec.aluctrl = ALUOP_ADD;
            end
            default:  legal = 1'b0;
        endcase
    end

    // Destination selection; writes to r0 are suppressed, invalid/illegal become NOP.
    always_comb begin
        id_ctrl = dec;
        id_wreg = dec.regdst ? bus.rt : bus.rd;
        if (id_wreg == '0) begin
            id_ctrl.regw = 1'b0;
        end
        if (!bus.instr_valid || !legal) begin
            id_ctrl = '0;
            id_wreg = '0;
        end
    end

    assign uses_rt = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_BEQ) ||
                     (bus.opcode == OP_BNE)   || (bus.opcode == OP_SW);

    assign hazard = ex_q.memr && (ex_wreg_q != '0) && bus.instr_valid &&
                    ((ex_wreg_q == bus.rs) || (uses_rt && (ex_wreg_q == bus.rt)));

    // A flush overrides the interlock: the dependent instruction is being killed anyway.
    assign stall_c = bus.mem_stall_i || (state != RUN) || (hazard && !bus.flush_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            ex_wreg_q  <= '0;
            mem_wreg_q <= '0;
            wb_wreg_q  <= '0;
        end else if (state == HALT) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            ex_wreg_q  <= '0;
            mem_wreg_q <= '0;
            wb_wreg_q  <= '0;
        end else if (!bus.mem_stall_i) begin
            mem_q      <= ex_q;
            mem_wreg_q <= ex_wreg_q;
            wb_q       <= mem_q;
            wb_wreg_q  <= mem_wreg_q;
            if ((state == RUN) && !bus.flush_i && !hazard) begin
                ex_q      <= id_ctrl;
                ex_wreg_q <= id_wreg;
                if (id_ctrl.brk) begin
                    state <= DRAIN;
                end
            end else begin
                ex_q      <= '0;
                ex_wreg_q <= '0;
            end
            // Halt on the edge that lands the BREAK word in WB.
            if ((state == DRAIN) && mem_q.brk) begin
                state <= HALT;
            end
        end
    end

    assign bus.stall_o   = stall_c;
    assign bus.illegal_o = bus.instr_valid && !legal;
    assign bus.halted_o  = (state == HALT);
    assign bus.ex_ctrl   = CW'(ex_q);
    assign bus.mem_ctrl  = CW'(mem_q);
    assign bus.wb_ctrl   = CW'(wb_q);
    assign bus.ex_wreg   = ex_wreg_q;
    assign bus.mem_wreg  = mem_wreg_q;
    assign bus.wb_wreg   = wb_wreg_q;

`ifdef CTRL_PERF_EN
    logic [31:0] retired_q;
    logic [31:0] stall_cnt_q;

    // Counters wrap naturally and freeze once halted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else if (state != HALT) begin
            if ((wb_q != '0) && !bus.mem_stall_i) begin
                retired_q <= retired_q + 32'd1;
            end
            if (stall_c && (state == RUN)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.retired_cnt = retired_q;
    assign bus.stall_cnt   = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode-model scoreboard on the EX/MEM/WB stage words,
// plus interlock, flush, memory-stall and BREAK-halt sequences.
module tb_ctrl_pipe;
    localparam int unsigned ALU_W = 5;
    localparam int unsigned EXT_W = 2;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CW    = 11 + ALU_W + EXT_W;

    localparam int M_HOLD   = 0;
    localparam int M_ISSUE  = 1;
    localparam int M_BUBBLE = 2;

    // Control-flag groups: {jump,branch,nbranch,regdst,alusrc,alushift,memr,mem2r,memw,regw,brk}
    localparam logic [10:0] F_JUMP  = 11'b100_0000_0000;
    localparam logic [10:0] F_BR    = 11'b010_0000_0000;
    localparam logic [10:0] F_NBR   = 11'b001_0000_0000;
    localparam logic [10:0] F_RDST  = 11'b000_1000_0000;
    localparam logic [10:0] F_ASRC  = 11'b000_0100_0000;
    localparam logic [10:0] F_SHIFT = 11'b000_0010_0000;
    localparam logic [10:0] F_MEMR  = 11'b000_0001_0000;
    localparam logic [10:0] F_M2R   = 11'b000_0000_1000;
    localparam logic [10:0] F_MEMW  = 11'b000_0000_0100;
    localparam logic [10:0] F_REGW  = 11'b000_0000_0010;
    localparam logic [10:0] F_BRK   = 11'b000_0000_0001;

    localparam logic [4:0] A_ADDU = 5'd0, A_SUBU = 5'd1, A_AND = 5'd2, A_OR  = 5'd3;
    localparam logic [4:0] A_XOR  = 5'd4, A_SLT  = 5'd5, A_SLL = 5'd6, A_SRL = 5'd7;
    localparam logic [4:0] A_SRA  = 5'd8, A_LUI  = 5'd9, A_ADD = 5'd10;
    localparam logic [1:0] E_ZERO = 2'd0, E_SIGN = 2'd1, E_HIGH = 2'd2;

    typedef struct packed {
        logic [CW-1:0]    c;
        logic [REG_W-1:0] w;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic valid, flush, mstall;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;

    ent_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic in_run = 1'b1;
    logic halted_now = 1'b0;
    logic [31:0] exp_ret = 32'd0;
    logic [31:0] exp_stl = 32'd0;

    ctrl_pipe_if #(.ALU_W(ALU_W), .EXT_W(EXT_W), .REG_W(REG_W)) bus ();

    assign bus.instr_valid = valid;
    assign bus.opcode      = op;
    assign bus.funct       = fn;
    assign bus.rs          = rs;
    assign bus.rt          = rt;
    assign bus.rd          = rd;
    assign bus.flush_i     = flush;
    assign bus.mem_stall_i = mstall;

    ctrl_pipe #(.ALU_W(ALU_W), .EXT_W(EXT_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ent_t model(input logic v, input logic [5:0] o, input logic [5:0] f,
                                   input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        logic [10:0] fl;
        logic [1:0]  e;
        logic [4:0]  a;
        logic        ok;
        ent_t        r;
        fl = '0; e = '0; a = '0; ok = 1'b1;
        case (o)
            6'h00: case (f)
                6'h21: begin fl = F_REGW; a = A_ADDU; end
                6'h23: begin fl = F_REGW; a = A_SUBU; end
                6'h2A: begin fl = F_REGW; a = A_SLT;  end
                6'h24: begin fl = F_REGW; a = A_AND;  end
                6'h25: begin fl = F_REGW; a = A_OR;   end
                6'h26: begin fl = F_REGW; a = A_XOR;  end
                6'h00: begin fl = F_REGW | F_SHIFT; a = A_SLL; end
                6'h02: begin fl = F_REGW | F_SHIFT; a = A_SRL; end
                6'h03: begin fl = F_REGW | F_SHIFT; a = A_SRA; end
                6'h0D: fl = F_BRK;
                default: ok = 1'b0;
            endcase
            6'h0D: begin fl = F_RDST | F_ASRC | F_REGW; e = E_ZERO; a = A_OR;  end
            6'h0F: begin fl = F_RDST | F_ASRC | F_REGW; e = E_HIGH; a = A_LUI; end
            6'h23: begin fl = F_RDST | F_ASRC | F_MEMR | F_M2R | F_REGW; e = E_SIGN; a = A_ADDU; end
            6'h2B: begin fl = F_ASRC | F_MEMW; e = E_SIGN; a = A_ADDU; end
            6'h04: begin fl = F_BR;  e = E_SIGN; a = A_SUBU; end
            6'h05: begin fl = F_NBR; e = E_SIGN; a = A_SUBU; end
            6'h02: fl = F_JUMP;
            6'h08: begin fl = F_RDST | F_ASRC | F_REGW; e = E_SIGN; a = A_ADD; end
            default: ok = 1'b0;
        endcase
        r.w = ((fl & F_RDST) != '0) ? t : d;
        if (r.w == 5'd0) fl = fl & ~F_REGW;
        r.c = {fl, e, a};
        if (!v || !ok) r = '0;
        if (s == 5'd31) r.w = r.w;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stages(input string tag);
        chk({tag, "_ex_ctrl"},  32'(bus.ex_ctrl),  32'(sb[2].c));
        chk({tag, "_ex_wreg"},  32'(bus.ex_wreg),  32'(sb[2].w));
        chk({tag, "_mem_ctrl"}, 32'(bus.mem_ctrl), 32'(sb[1].c));
        chk({tag, "_mem_wreg"}, 32'(bus.mem_wreg), 32'(sb[1].w));
        chk({tag, "_wb_ctrl"},  32'(bus.wb_ctrl),  32'(sb[0].c));
        chk({tag, "_wb_wreg"},  32'(bus.wb_wreg),  32'(sb[0].w));
    endtask

    task automatic set_id(input logic v, input logic [5:0] o, input logic [5:0] f,
                          input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        valid = v; op = o; fn = f; rs = s; rt = t; rd = d;
    endtask

    // One clock: combinational checks before the edge, stage checks after it.
    task automatic step(input string tag, input int mode, input logic stall_exp,
                        input logic illegal_exp, input logic halted_exp);
        ent_t e;
        #3;
        chk({tag, "_stall"},   32'(bus.stall_o),   32'(stall_exp));
        chk({tag, "_illegal"}, 32'(bus.illegal_o), 32'(illegal_exp));
        e = (mode == M_ISSUE) ? model(valid, op, fn, rs, rt, rd) : ent_t'('0);
        if (!halted_now) begin
            if ((sb[0].c != '0) && !mstall) exp_ret = exp_ret + 32'd1;
            if (stall_exp && in_run)        exp_stl = exp_stl + 32'd1;
        end
        @(posedge clk);
        #1;
        if (mode != M_HOLD) sb.push_back(e);
        if (sb.size() > 3) void'(sb.pop_front());
        chk_stages(tag);
        chk({tag, "_halted"}, 32'(bus.halted_o), 32'(halted_exp));
        halted_now = halted_exp;
`ifdef CTRL_PERF_EN
        chk({tag, "_retired_cnt"}, bus.retired_cnt, exp_ret);
        chk({tag, "_stall_cnt"},   bus.stall_cnt,   exp_stl);
`endif
    endtask

    task automatic issue(input string tag, input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        set_id(1'b1, o, f, s, t, d);
        step(tag, M_ISSUE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < n; i++) step("idle", M_ISSUE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        flush = 1'b0;
        mstall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) sb.push_back('0);
        halted_now = 1'b0;
        in_run = 1'b1;
        exp_ret = 32'd0;
        exp_stl = 32'd0;
        chk_stages("reset");
        chk("reset_stall",  32'(bus.stall_o),  32'd0);
        chk("reset_halted", 32'(bus.halted_o), 32'd0);
`ifdef CTRL_PERF_EN
        chk("reset_retired_cnt", bus.retired_cnt, 32'd0);
        chk("reset_stall_cnt",   bus.stall_cnt,   32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        mstall = 1'b0;
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        do_reset();

        // ADDU rd=3 flows ID -> EX -> MEM -> WB without stalling.
        issue("addu", 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);
        chk("addu_ex_regw", 32'(bus.ex_ctrl[8]), 32'd1);
        chk("addu_ex_aluctrl", 32'(bus.ex_ctrl[4:0]), 32'(A_ADDU));
        idle(2);
        chk("addu_wb_wreg", 32'(bus.wb_wreg), 32'd3);
        idle(1);

        // Remaining decode table, back to back.
        issue("subu",  6'h00, 6'h23, 5'd1, 5'd2, 5'd4);
        issue("slt",   6'h00, 6'h2A, 5'd1, 5'd2, 5'd5);
        issue("sll_r0", 6'h00, 6'h00, 5'd0, 5'd2, 5'd0);
        issue("srl",   6'h00, 6'h02, 5'd0, 5'd2, 5'd6);
        issue("sra",   6'h00, 6'h03, 5'd0, 5'd2, 5'd7);
        issue("and",   6'h00, 6'h24, 5'd1, 5'd2, 5'd8);
        issue("or",    6'h00, 6'h25, 5'd1, 5'd2, 5'd9);
        issue("xor",   6'h00, 6'h26, 5'd1, 5'd2, 5'd10);
        issue("lui",   6'h0F, 6'h11, 5'd0, 5'd11, 5'd2);
        issue("beq",   6'h04, 6'h08, 5'd1, 5'd2, 5'd0);
        issue("bne",   6'h05, 6'h08, 5'd1, 5'd2, 5'd0);
        issue("j",     6'h02, 6'h10, 5'd3, 5'd4, 5'd5);
        issue("addi",  6'h08, 6'h04, 5'd1, 5'd12, 5'd0);
        issue("addi_r0", 6'h08, 6'h04, 5'd1, 5'd0, 5'd0);
        idle(3);

        // Load-use through rs: one bubble, then ADDU issues.
        issue("lw", 6'h23, 6'h04, 5'd1, 5'd5, 5'd0);
        set_id(1'b1, 6'h00, 6'h21, 5'd5, 5'd2, 5'd6);
        step("lu_rs_bubble", M_BUBBLE, 1'b1, 1'b0, 1'b0);
        step("lu_rs_issue",  M_ISSUE,  1'b0, 1'b0, 1'b0);
        idle(3);

        // Load-use through rt of SW; ORI ignores rt; LW to r0 never interlocks.
        issue("lw2", 6'h23, 6'h04, 5'd1, 5'd5, 5'd0);
        set_id(1'b1, 6'h2B, 6'h04, 5'd1, 5'd5, 5'd0);
        step("lu_rt_bubble", M_BUBBLE, 1'b1, 1'b0, 1'b0);
        step("lu_rt_issue",  M_ISSUE,  1'b0, 1'b0, 1'b0);
        issue("lw3", 6'h23, 6'h04, 5'd1, 5'd5, 5'd0);
        issue("ori_rt5", 6'h0D, 6'h04, 5'd1, 5'd5, 5'd0);
        issue("lw_r0", 6'h23, 6'h04, 5'd1, 5'd0, 5'd0);
        issue("addu_after_lw_r0", 6'h00, 6'h21, 5'd0, 5'd0, 5'd7);
        idle(3);

        // Flush beats a simultaneous hazard: SW is lost, no stall.
        issue("lw4", 6'h23, 6'h04, 5'd1, 5'd5, 5'd0);
        set_id(1'b1, 6'h2B, 6'h04, 5'd1, 5'd5, 5'd0);
        flush = 1'b1;
        step("flush_hazard", M_BUBBLE, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        idle(3);

        // Memory stall of four cycles with ORI in EX.
        issue("ori", 6'h0D, 6'h04, 5'd1, 5'd7, 5'd0);
        set_id(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd13);
        mstall = 1'b1;
        for (int i = 0; i < 4; i++) step("mstall", M_HOLD, 1'b1, 1'b0, 1'b0);
        mstall = 1'b0;
        step("mstall_release", M_ISSUE, 1'b0, 1'b0, 1'b0);
        chk("ori_in_mem", 32'(bus.mem_wreg), 32'd7);
        idle(3);

        // Illegal opcode: flagged in ID, NOP in EX.
        set_id(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
        step("illegal_op", M_ISSUE, 1'b0, 1'b1, 1'b0);
        set_id(1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3);
        step("illegal_fn", M_ISSUE, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Flushed BREAK must not halt.
        set_id(1'b1, 6'h00, 6'h0D, 5'd0, 5'd0, 5'd0);
        flush = 1'b1;
        step("brk_flushed", M_BUBBLE, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        idle(4);

        // Reset in the middle of a drain.
        set_id(1'b1, 6'h00, 6'h0D, 5'd0, 5'd0, 5'd0);
        step("brk_a", M_ISSUE, 1'b0, 1'b0, 1'b0);
        in_run = 1'b0;
        set_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        step("drain_a", M_BUBBLE, 1'b1, 1'b0, 1'b0);
        do_reset();

        // BREAK then ADDI: ADDI never issues, halt three cycles after decode.
        issue("pre_brk", 6'h0D, 6'h00, 5'd1, 5'd14, 5'd0);
        set_id(1'b1, 6'h00, 6'h0D, 5'd0, 5'd0, 5'd0);
        step("brk", M_ISSUE, 1'b0, 1'b0, 1'b0);
        in_run = 1'b0;
        set_id(1'b1, 6'h08, 6'h04, 5'd1, 5'd9, 5'd0);
        step("drain1", M_BUBBLE, 1'b1, 1'b0, 1'b0);
        step("drain2", M_BUBBLE, 1'b1, 1'b0, 1'b1);
        chk("halt_wb_brk", 32'(bus.wb_ctrl[7]), 32'd1);
        step("halt1", M_BUBBLE, 1'b1, 1'b0, 1'b1);
        mstall = 1'b1;
        step("halt_mstall", M_BUBBLE, 1'b1, 1'b0, 1'b1);
        mstall = 1'b0;
        step("halt2", M_BUBBLE, 1'b1, 1'b0, 1'b1);
        do_reset();
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
